// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the fetch control logic and the PC sequencer.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_offset;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic             halt_req;
    logic             resume;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus1;
    logic             ir_load;
    logic             halted;
    logic             trap;

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_target, halt_req, resume,
        input  pc, pc_plus1, ir_load, halted, trap
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_target, halt_req, resume,
        output pc, pc_plus1, ir_load, halted, trap
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with BOOT/RUN/HALT control and IR load enable.
// Define PC_TRAP_EN to trap (sticky flag + HALT) on PC wrap instead of wrapping silently.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);
    localparam int unsigned EW = WIDTH + 2;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_pc_br;
    logic             r_trap;
    logic             w_trap_set;
    logic             w_ir_load;
    logic             w_inc_ovf;
    logic             w_br_ovf;

    assign w_pc_inc = r_pc + WIDTH'(1);

`ifdef PC_TRAP_EN
    // Signed, unbounded branch target: negative or above 2^WIDTH-1 shows in the top two bits.
    logic [EW-1:0] w_br_ext;
    assign w_br_ext  = EW'(r_pc) + EW'(1) + {{2{bus.branch_offset[WIDTH-1]}}, bus.branch_offset};
    assign w_pc_br   = w_br_ext[WIDTH-1:0];
    assign w_br_ovf  = |w_br_ext[EW-1:WIDTH];
    assign w_inc_ovf = &r_pc;
`else
    assign w_pc_br   = w_pc_inc + bus.branch_offset;
    assign w_br_ovf  = 1'b0;
    assign w_inc_ovf = 1'b0;
`endif

    // Next-state, next-PC and IR load enable
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_trap_set   = 1'b0;
        w_ir_load    = 1'b0;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN: begin
                w_ir_load = ~bus.stall;
                if (!bus.stall) begin
                    if (bus.halt_req) begin
                        w_state_next = ST_HALT;
                    end else if (bus.jump) begin
                        w_pc_next = bus.jump_target;
                    end else if (bus.branch_taken) begin
                        if (w_br_ovf) begin
                            w_trap_set   = 1'b1;
                            w_state_next = ST_HALT;
                        end else begin
                            w_pc_next = w_pc_br;
                        end
                    end else if (w_inc_ovf) begin
                        w_trap_set   = 1'b1;
                        w_state_next = ST_HALT;
                    end else begin
                        w_pc_next = w_pc_inc;
                    end
                end
            end
            ST_HALT: begin
                if (!bus.stall && bus.resume && !bus.halt_req) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_VECTOR;
            r_trap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_trap_set) begin
                r_trap <= 1'b1;
            end
        end
    end

    assign bus.pc       = r_pc;
    assign bus.pc_plus1 = w_pc_inc;
    assign bus.ir_load  = w_ir_load;
    assign bus.halted   = (r_state == ST_HALT);
    assign bus.trap     = r_trap;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed cycles push expectations, a negedge monitor checks.
module tb_pc_sequencer;
    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        ir_load;
        logic        halted;
        logic        trap;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   n_cmp;
    int   n_bad;
    logic exp_trap;

    pc_sequencer_if #(.WIDTH(16)) bus ();

    pc_sequencer #(.WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pop one expectation per falling edge and compare all outputs.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [15:0] p1;
            e  = sb.pop_front();
            p1 = e.pc + 16'd1;
            n_cmp++;
            if (bus.pc !== e.pc || bus.pc_plus1 !== p1 || bus.ir_load !== e.ir_load ||
                bus.halted !== e.halted || bus.trap !== e.trap) begin
                n_bad++;
                $display("FAIL %s: got pc=%h pc_plus1=%h ir_load=%b halted=%b trap=%b, want pc=%h pc_plus1=%h ir_load=%b halted=%b trap=%b",
                         e.name, bus.pc, bus.pc_plus1, bus.ir_load, bus.halted, bus.trap,
                         e.pc, p1, e.ir_load, e.halted, e.trap);
            end
        end
    end

    // Push expected outputs for the current inputs, then advance one clock edge.
    task automatic cyc(input string nm, input logic [15:0] epc, input logic eir, input logic ehl);
        exp_t e;
        e.name    = nm;
        e.pc      = epc;
        e.ir_load = eir;
        e.halted  = ehl;
        e.trap    = exp_trap;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_trap = 1'b0;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_offset = 16'h0000;
        bus.jump = 1'b0;
        bus.jump_target = 16'h0000;
        bus.halt_req = 1'b0;
        bus.resume = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        cyc("reset", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("boot", 16'h0000, 1'b0, 1'b0);
        cyc("run_first", 16'h0000, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) cyc("free_run", 16'(i), 1'b1, 1'b0);

        bus.jump = 1'b1; bus.jump_target = 16'h0010;
        cyc("jump_0010", 16'h0006, 1'b1, 1'b0);
        bus.jump = 1'b0; bus.branch_taken = 1'b1; bus.branch_offset = 16'hFFFD;
        cyc("branch_m3", 16'h0010, 1'b1, 1'b0);
        bus.jump = 1'b1; bus.jump_target = 16'h1234;
        cyc("jump_and_branch", 16'h000E, 1'b1, 1'b0);
        bus.jump = 1'b0; bus.branch_taken = 1'b0;
        cyc("after_jump", 16'h1234, 1'b1, 1'b0);

        bus.jump = 1'b1; bus.jump_target = 16'h0020;
        cyc("jump_0020", 16'h1235, 1'b1, 1'b0);
        bus.jump = 1'b0; bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) cyc("stall", 16'h0020, 1'b0, 1'b0);
        bus.stall = 1'b0;
        cyc("unstall", 16'h0020, 1'b1, 1'b0);
        cyc("post_stall", 16'h0021, 1'b1, 1'b0);

        bus.jump = 1'b1; bus.jump_target = 16'h0030;
        cyc("jump_0030", 16'h0022, 1'b1, 1'b0);
        bus.jump = 1'b0; bus.halt_req = 1'b1;
        cyc("halt_req", 16'h0030, 1'b1, 1'b0);
        bus.halt_req = 1'b0;
        for (int i = 0; i < 4; i++) cyc("halt_hold", 16'h0030, 1'b0, 1'b1);
        bus.halt_req = 1'b1; bus.resume = 1'b1;
        cyc("halt_and_resume", 16'h0030, 1'b0, 1'b1);
        bus.halt_req = 1'b0;
        cyc("resume", 16'h0030, 1'b0, 1'b1);
        bus.resume = 1'b0;
        cyc("refetch", 16'h0030, 1'b1, 1'b0);
        cyc("post_resume", 16'h0031, 1'b1, 1'b0);

        bus.stall = 1'b1; bus.halt_req = 1'b1;
        cyc("stall_over_halt", 16'h0032, 1'b0, 1'b0);
        bus.stall = 1'b0;
        cyc("halt_after_stall", 16'h0032, 1'b1, 1'b0);
        bus.halt_req = 1'b0;
        cyc("halted_again", 16'h0032, 1'b0, 1'b1);
        rst = 1'b1;
        cyc("rst_in_halt", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("boot_again", 16'h0000, 1'b0, 1'b0);
        cyc("run_again", 16'h0000, 1'b1, 1'b0);

        bus.jump = 1'b1; bus.jump_target = 16'hFFFF;
        cyc("jump_ffff", 16'h0001, 1'b1, 1'b0);
        bus.jump = 1'b0;
`ifdef PC_TRAP_EN
        cyc("wrap_inc", 16'hFFFF, 1'b1, 1'b0);
        exp_trap = 1'b1;
        cyc("trapped", 16'hFFFF, 1'b0, 1'b1);
        cyc("trap_sticky", 16'hFFFF, 1'b0, 1'b1);
`else
        cyc("wrap_inc", 16'hFFFF, 1'b1, 1'b0);
        cyc("wrapped", 16'h0000, 1'b1, 1'b0);
        bus.branch_taken = 1'b1; bus.branch_offset = 16'hFFFD;
        cyc("branch_under", 16'h0001, 1'b1, 1'b0);
        bus.branch_taken = 1'b0;
        cyc("branch_wrapped", 16'hFFFF, 1'b1, 1'b0);
`endif

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
